// File: rtl/ring_pkg.sv
// Shared ring-stop field widths and packet type encodings.
package ring_pkg;

  localparam int ADDR_W = 36;
  localparam int ID_W   = 5;
  localparam int TYPE_W = 3;

  typedef enum logic [TYPE_W-1:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    WR_REQ  = 3'd2,
    RD_RESP = 3'd3,
    WR_ACK  = 3'd4
  } pkt_type_e;

endpackage

// File: rtl/ring_tx_fifo.sv
// Synchronous FIFO holding client TX packets until a ring slot can take them.
module ring_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);
  assign count = cnt;
  assign head  = mem[rd_ptr];

endmodule

// File: rtl/ring_stop_controller.sv
// Decides per cycle whether a ring stop forwards or overwrites its slot; consumes local packets and injects queued TX.
module ring_stop_controller
  import ring_pkg::*;
#(
  parameter int DATA_W    = 512,
  parameter int NODE_ID   = 0,
  parameter int TXQ_DEPTH = 4,
  parameter int INJ_BURST = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [ADDR_W-1:0]          slot_addr,
  input  logic [DATA_W-1:0]          slot_data,
  input  logic [ID_W-1:0]            slot_id,
  input  logic [TYPE_W-1:0]          slot_type,
  output logic                       overwrite,
  output logic [ADDR_W-1:0]          ovr_addr,
  output logic [DATA_W-1:0]          ovr_data,
  output logic [ID_W-1:0]            ovr_id,
  output logic [TYPE_W-1:0]          ovr_type,
  input  logic                       tx_valid,
  output logic                       tx_ready,
  input  logic [ADDR_W-1:0]          tx_addr,
  input  logic [DATA_W-1:0]          tx_data,
  input  logic [ID_W-1:0]            tx_id,
  input  logic [TYPE_W-1:0]          tx_type,
  output logic                       rx_valid,
  input  logic                       rx_ready,
  output logic [ADDR_W-1:0]          rx_addr,
  output logic [DATA_W-1:0]          rx_data,
  output logic [TYPE_W-1:0]          rx_type,
  output logic [$clog2(TXQ_DEPTH):0] txq_count
);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [ID_W-1:0]   id;
    logic [TYPE_W-1:0] pkt_type;
  } ring_pkt_t;

  localparam int BW = $clog2(INJ_BURST + 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(INJ_BURST);
  localparam logic [ID_W-1:0] MY_ID = ID_W'(NODE_ID);

  ring_pkt_t      tx_pkt;
  ring_pkt_t      head;
  logic           fifo_full;
  logic           fifo_empty;
  logic           push;
  logic           mine;
  logic           rx_free;
  logic           consume;
  logic           can_inj;
  logic           inject;
  logic [BW-1:0]  burst_cnt;

  assign tx_pkt = '{addr: tx_addr, data: tx_data, id: tx_id, pkt_type: tx_type};

  assign tx_ready = !fifo_full && !rst;
  assign push     = tx_valid && tx_ready;

  ring_tx_fifo #(
    .WIDTH ($bits(ring_pkt_t)),
    .DEPTH (TXQ_DEPTH)
  ) u_txq (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (inject),
    .wdata (tx_pkt),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (txq_count),
    .head  (head)
  );

  // A mine slot that cannot be consumed simply recirculates until RX frees up.
  assign mine    = (slot_type != IDLE) && (slot_id == MY_ID);
  assign rx_free = !rx_valid || rx_ready;
  assign consume = mine && rx_free;
  assign can_inj = !fifo_empty && (burst_cnt < BURST_MAX);
  assign inject  = can_inj && ((slot_type == IDLE) || consume);

  assign overwrite = consume || inject;
  assign ovr_addr  = inject ? head.addr     : '0;
  assign ovr_data  = inject ? head.data     : '0;
  assign ovr_id    = inject ? head.id       : '0;
  assign ovr_type  = inject ? head.pkt_type : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_valid <= 1'b0;
      rx_addr  <= '0;
      rx_data  <= '0;
      rx_type  <= '0;
    end else if (consume) begin
      rx_valid <= 1'b1;
      rx_addr  <= slot_addr;
      rx_data  <= slot_data;
      rx_type  <= slot_type;
    end else if (rx_valid && rx_ready) begin
      rx_valid <= 1'b0;
    end
  end

  // Any cycle without an injection clears the run, so a full burst forces one idle slot downstream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      burst_cnt <= '0;
    end else if (inject) begin
      burst_cnt <= (burst_cnt == BURST_MAX) ? BURST_MAX : burst_cnt + 1'b1;
    end else begin
      burst_cnt <= '0;
    end
  end

endmodule
